// File: rtl/dec_sync_ctrl_pkg.sv
// dec_sync_ctrl_pkg: shared state encoding and constants for the 8b/10b decoder sync controller
package dec_sync_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_LOS   = 3'd0,
        ST_CDET  = 3'd1,
        ST_SYNC1 = 3'd2,
        ST_SYNC2 = 3'd3,
        ST_SYNC3 = 3'd4,
        ST_SYNC4 = 3'd5
    } sync_state_e;

    localparam logic [7:0] K28_5         = 8'hBC;
    localparam int         COMMA_CNT_DEF = 3;
    localparam int         GOOD_RUN_DEF  = 4;

endpackage

// File: rtl/dec_err_cnt.sv
// dec_err_cnt: 8-bit saturating event counter with a clear that beats increment
module dec_err_cnt (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] cnt
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // next count: clear wins, otherwise count up and stick at 8'hFF
    always_comb begin
        cnt_d = clr ? 8'h00 : ((inc && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q);
    end

    // count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= 8'h00;
        else          cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/dec_sync_ctrl.sv
// dec_sync_ctrl: comma-based word sync state machine and decoder control / receive data path
module dec_sync_ctrl
    import dec_sync_ctrl_pkg::*;
#(
    parameter int COMMA_CNT = COMMA_CNT_DEF,
    parameter int GOOD_RUN  = GOOD_RUN_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cfg_enable,
    input  logic       cfg_idle_del,
    input  logic       cnt_clr,
    input  logic       dec_valid,
    input  logic [7:0] dec_dataout,
    input  logic       dec_kout,
    input  logic       dec_kerr,
    input  logic       dec_rderr,
    output logic       dec_ena,
    output logic       dec_idle_del,
    output logic       dec_rdforce,
    output logic       dec_rdin,
    output logic       sync_status,
    output logic [2:0] sync_state,
    output logic [7:0] rx_data,
    output logic       rx_k,
    output logic       rx_valid,
    output logic [7:0] err_cnt
);

    sync_state_e state_q, state_d;
    logic [7:0]  comma_q, comma_d;
    logic [7:0]  good_q, good_d;
    logic        ena_q, ena_d;
    logic        idle_q, idle_d;
    logic        rdforce_q, rdforce_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_k_q, rx_k_d;
    logic        rx_valid_q, rx_valid_d;
    logic        is_err;
    logic        is_comma;

    // error outranks comma; neither exists without dec_valid
    assign is_err      = dec_valid && (dec_kerr || dec_rderr);
    assign is_comma    = dec_valid && !is_err && dec_kout && (dec_dataout == K28_5);
    assign sync_status = state_q inside {ST_SYNC1, ST_SYNC2, ST_SYNC3, ST_SYNC4};

    // sync state machine: acquire on COMMA_CNT commas, decay one level per error, recover on GOOD_RUN good words
    always_comb begin
        state_d = state_q;
        comma_d = comma_q;
        good_d  = good_q;
        if (!cfg_enable) begin
            state_d = ST_LOS;
            comma_d = 8'd0;
            good_d  = 8'd0;
        end else if (dec_valid) begin
            case (state_q)
                ST_LOS: begin
                    if (is_comma) begin
                        state_d = ST_CDET;
                        comma_d = 8'd1;
                    end
                end
                ST_CDET: begin
                    if (is_err) begin
                        state_d = ST_LOS;
                        comma_d = 8'd0;
                    end else if (is_comma) begin
                        comma_d = comma_q + 8'd1;
                        if (comma_d >= 8'(COMMA_CNT)) begin
                            state_d = ST_SYNC1;
                            comma_d = 8'd0;
                            good_d  = 8'd0;
                        end
                    end
                end
                ST_SYNC1: begin
                    if (is_err) begin
                        state_d = ST_SYNC2;
                        good_d  = 8'd0;
                    end
                end
                ST_SYNC2, ST_SYNC3, ST_SYNC4: begin
                    if (is_err) begin
                        state_d = (state_q == ST_SYNC4) ? ST_LOS : sync_state_e'(state_q + 3'd1);
                        good_d  = 8'd0;
                    end else begin
                        good_d = good_q + 8'd1;
                        if (good_d >= 8'(GOOD_RUN)) begin
                            state_d = sync_state_e'(state_q - 3'd1);
                            good_d  = 8'd0;
                        end
                    end
                end
                default: begin
                    state_d = ST_LOS;
                    comma_d = 8'd0;
                    good_d  = 8'd0;
                end
            endcase
        end
    end

    // decoder control and receive data path, all one cycle behind their inputs
    always_comb begin
        ena_d      = cfg_enable;
        idle_d     = cfg_idle_del && sync_status;
        rdforce_d  = (state_d == ST_LOS);
        rx_data_d  = dec_valid ? dec_dataout : rx_data_q;
        rx_k_d     = dec_valid ? dec_kout : rx_k_q;
        rx_valid_d = dec_valid && sync_status && !is_err;
    end

    // state and output registers; reset parks the link in LOS with disparity forced
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_LOS;
            comma_q    <= 8'd0;
            good_q     <= 8'd0;
            ena_q      <= 1'b0;
            idle_q     <= 1'b0;
            rdforce_q  <= 1'b1;
            rx_data_q  <= 8'h00;
            rx_k_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            comma_q    <= comma_d;
            good_q     <= good_d;
            ena_q      <= ena_d;
            idle_q     <= idle_d;
            rdforce_q  <= rdforce_d;
            rx_data_q  <= rx_data_d;
            rx_k_q     <= rx_k_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    dec_err_cnt u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (is_err && sync_status),
        .cnt     (err_cnt)
    );

    assign sync_state   = state_q;
    assign dec_ena      = ena_q;
    assign dec_idle_del = idle_q;
    assign dec_rdforce  = rdforce_q;
    assign dec_rdin     = 1'b0;
    assign rx_data      = rx_data_q;
    assign rx_k         = rx_k_q;
    assign rx_valid     = rx_valid_q;

endmodule
